multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//   Moore-style FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory, writeback.
//   Consumes the opcode field split out by the decoder, ALU zero flag and a memory ready handshake.
//   Drives every datapath enable/mux select, one state per clock.
//   Adds a memory-wait timeout and a retire pulse for the cycle/instruction counters.
// PARAMETERS
//   MEM_TIMEOUT  255  max cycles a memory state waits for mem_ready before bus error (1..255)
// PORTS
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous, active-high reset
//   opcode       in   6  instruction[31:26], from IR
//   zero         in   1  ALU zero flag (branch compare)
//   mem_ready    in   1  memory completes read/write this cycle
//   pc_en        out  1  PC load = pc_write | (pc_write_cond & zero)
//   iord         out  1  0: mem addr = PC, 1: mem addr = ALUOut
//   mem_read     out  1  memory read request, held until mem_ready
//   mem_write    out  1  memory write request, held until mem_ready
//   ir_write     out  1  latch instruction register
//   reg_dst      out  1  0: write rt, 1: write rd
//   mem_to_reg   out  1  0: write ALUOut, 1: write MDR
//   reg_write    out  1  register file write enable
//   alu_src_a    out  1  0: PC, 1: A register
//   alu_src_b    out  2  00 B, 01 const 4, 10 sext imm16, 11 sext imm16<<2
//   alu_op       out  2  00 add, 01 sub, 10 use func field
//   pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],addr26,2'b00}
//   instr_done   out  1  1-cycle pulse in final cycle of each retired instruction
//   illegal      out  1  sticky: unsupported opcode decoded
//   bus_error    out  1  sticky: memory timeout
// BEHAVIOUR
//   Reset: state=FETCH, wait counter=0, illegal=bus_error=0. While reset high, all outputs are 0.
//   States / outputs (unlisted outputs 0):
//     FETCH   mem_read, iord=0, src_a=0, src_b=01, op=00, pc_source=00; ir_write & pc_write only in mem_ready cycle
//     DECODE  src_a=0, src_b=11, op=00 (branch target -> ALUOut). Next state by opcode:
//               000000 R -> EXEC; 100011 lw / 101011 sw -> MEMADR; 000100 beq -> BRANCH;
//               000010 j -> JUMP; 001000 addi -> ADDI_EX; else -> ILLEGAL
//     MEMADR  src_a=1, src_b=10, op=00 -> MEMRD (lw) / MEMWR (sw)
//     MEMRD   mem_read, iord=1; advance to MEMWB on mem_ready
//     MEMWB   reg_write, reg_dst=0, mem_to_reg=1, instr_done -> FETCH
//     MEMWR   mem_write, iord=1; on mem_ready: instr_done -> FETCH
//     EXEC    src_a=1, src_b=00, op=10 -> RWB
//     RWB     reg_write, reg_dst=1, mem_to_reg=0, instr_done -> FETCH
//     BRANCH  src_a=1, src_b=00, op=01, pc_write_cond, pc_source=01, instr_done -> FETCH
//     JUMP    pc_write, pc_source=10, instr_done -> FETCH
//     ADDI_EX src_a=1, src_b=10, op=00 -> ADDI_WB
//     ADDI_WB reg_write, reg_dst=0, mem_to_reg=0, instr_done -> FETCH
//     ILLEGAL illegal=1, all strobes 0; terminal until reset
//     BUSERR  bus_error=1, all strobes 0; terminal until reset
//   Latency at mem_ready=1 always: R/addi/sw 4 cycles, lw 5, beq/j 3.
//   Wait states (FETCH, MEMRD, MEMWR): request held stable, no other strobe changes, until mem_ready.
//   Timeout: 8-bit counter cleared on entering a wait state, +1 each cycle in it with mem_ready=0.
//     Counter == MEM_TIMEOUT with mem_ready=0 -> BUSERR next cycle. mem_ready in that same cycle wins (normal advance).
//   pc_en computed combinationally from state and zero; the only output not purely state-derived
//     besides FETCH ir_write/pc_write and MEMWR instr_done (mem_ready-qualified).
//   Reset asserted mid-instruction: immediate return to FETCH, sticky flags cleared, no strobe glitch to 1.
// TESTING
//   addi (0x20090005), mem_ready=1 -> states FETCH,DECODE,ADDI_EX,ADDI_WB; reg_write=1 only in cycle 4; instr_done once
//   lw with mem_ready low 3 cycles in MEMRD -> mem_read,iord held 4 cycles; total 8 cycles; MEMWB mem_to_reg=1
//   beq, zero=1 then zero=0 -> pc_en=1 / pc_en=0 in BRANCH cycle; pc_source=01
//   opcode 111111 -> ILLEGAL after DECODE, illegal=1 sticky, all strobes 0 until reset
//   MEM_TIMEOUT=4, mem_ready=0 in FETCH -> BUSERR after 5 cycles; repeat with mem_ready=1 at count 4 -> DECODE
//   reset pulsed in MEMWR -> next cycle FETCH, mem_write=0, no instr_done

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback),
// with a memory-wait timeout that traps into a bus-error state.
module multicycle_control #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_RWB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB, S_ILLEGAL, S_BUSERR
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       w_is_wait;
    logic       w_timeout;

    logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_instr_done;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            // Only a stalled wait state keeps counting; any move clears it for the next wait.
            if (w_is_wait && !mem_ready && (w_next_state == r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
        end
    end

    assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (r_wait_cnt == MEM_TIMEOUT);

    // Memory handshake: mem_read/mem_write is a request held constant while the FSM sits in
    // its wait state; the transfer completes in the cycle mem_ready=1 is seen, and the FSM
    // advances on the following edge. No other strobe changes while waiting.
    always_comb begin
        w_next_state    = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_BUSERR;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_R:         w_next_state = S_EXEC;
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EX;
                    default:      w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (mem_ready)      w_next_state = S_MEMWB;
                else if (w_timeout) w_next_state = S_BUSERR;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_BUSERR;
                end
            end
            S_EXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b10;
                w_next_state = S_RWB;
            end
            S_RWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
                w_next_state    = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ADDI_EX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = r_state;
        endcase
    end

    // Outputs are forced low while reset is high so an async reset never lets a strobe glitch.
    assign pc_en      = ~reset & (w_pc_write | (w_pc_write_cond & zero));
    assign iord       = ~reset & w_iord;
    assign mem_read   = ~reset & w_mem_read;
    assign mem_write  = ~reset & w_mem_write;
    assign ir_write   = ~reset & w_ir_write;
    assign reg_dst    = ~reset & w_reg_dst;
    assign mem_to_reg = ~reset & w_mem_to_reg;
    assign reg_write  = ~reset & w_reg_write;
    assign alu_src_a  = ~reset & w_alu_src_a;
    assign alu_src_b  = reset ? 2'b00 : w_alu_src_b;
    assign alu_op     = reset ? 2'b00 : w_alu_op;
    assign pc_source  = reset ? 2'b00 : w_pc_source;
    assign instr_done = ~reset & w_instr_done;
    assign illegal    = ~reset & (r_state == S_ILLEGAL);
    assign bus_error  = ~reset & (r_state == S_BUSERR);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected output bundles from an instruction-level
// model are queued by the driver and checked by an independent negedge monitor.
module tb_multicycle_control;
  localparam int W = 18;
  localparam logic [7:0] TMO = 8'd4;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal, bus_error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] dbg_state;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    ST_RST, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR, ST_EXEC,
    ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDI_EX, ST_ADDI_WB, ST_ILL, ST_BERR
  } step_e;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  // reference model: output bundle for one cycle of a given instruction step
  function automatic logic [W-1:0] exp_of(input step_e s, input logic mr, input logic z);
    logic e_pc_en, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_sa, e_done, e_ill, e_be;
    logic [1:0] e_sb, e_op, e_ps;
    {e_pc_en, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_sa} = 9'd0;
    {e_done, e_ill, e_be} = 3'd0;
    e_sb = 2'b00; e_op = 2'b00; e_ps = 2'b00;
    case (s)
      ST_FETCH:   begin e_mrd = 1; e_sb = 2'b01; e_irw = mr; e_pc_en = mr; end
      ST_DECODE:  e_sb = 2'b11;
      ST_MEMADR:  begin e_sa = 1; e_sb = 2'b10; end
      ST_MEMRD:   begin e_mrd = 1; e_iord = 1; end
      ST_MEMWB:   begin e_rw = 1; e_m2r = 1; e_done = 1; end
      ST_MEMWR:   begin e_mwr = 1; e_iord = 1; e_done = mr; end
      ST_EXEC:    begin e_sa = 1; e_op = 2'b10; end
      ST_RWB:     begin e_rw = 1; e_rdst = 1; e_done = 1; end
      ST_BRANCH:  begin e_sa = 1; e_op = 2'b01; e_ps = 2'b01; e_pc_en = z; e_done = 1; end
      ST_JUMP:    begin e_pc_en = 1; e_ps = 2'b10; e_done = 1; end
      ST_ADDI_EX: begin e_sa = 1; e_sb = 2'b10; end
      ST_ADDI_WB: begin e_rw = 1; e_done = 1; end
      ST_ILL:     e_ill = 1;
      ST_BERR:    e_be = 1;
      default:    ;
    endcase
    return {e_pc_en, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_sa,
            e_sb, e_op, e_ps, e_done, e_ill, e_be};
  endfunction

  // driver: one clock cycle of stimulus plus its expected response
  task automatic cyc(input step_e s, input logic mr, input logic z, input logic [5:0] op,
                     input logic rst);
    reset = rst; mem_ready = mr; zero = z; opcode = op;
    exp_q.push_back(exp_of(s, mr, z));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input step_e s, input int n, input logic [5:0] op);
    for (int k = 0; k < n; k++) cyc(s, 1'b0, 1'($urandom_range(0, 1)), op, 1'b0);
    cyc(s, 1'b1, 1'($urandom_range(0, 1)), op, 1'b0);
  endtask

  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      default: return 6'b001000;
    endcase
  endfunction

  // one instruction: kind 0=R 1=lw 2=sw 3=beq 4=j 5=addi
  task automatic run_instr(input int kind, input int f_wait, input int m_wait, input logic z);
    logic [5:0] op;
    op = op_of(kind);
    wait_phase(ST_FETCH, f_wait, 6'($urandom_range(0, 63)));
    cyc(ST_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, 1'b0);
    case (kind)
      0: begin cyc(ST_EXEC, 1'($urandom_range(0, 1)), z, op, 1'b0); cyc(ST_RWB, 1'($urandom_range(0, 1)), z, op, 1'b0); end
      1: begin cyc(ST_MEMADR, 1'b0, z, op, 1'b0); wait_phase(ST_MEMRD, m_wait, op); cyc(ST_MEMWB, 1'b0, z, op, 1'b0); end
      2: begin cyc(ST_MEMADR, 1'b0, z, op, 1'b0); wait_phase(ST_MEMWR, m_wait, op); end
      3: cyc(ST_BRANCH, 1'($urandom_range(0, 1)), z, op, 1'b0);
      4: cyc(ST_JUMP, 1'($urandom_range(0, 1)), z, op, 1'b0);
      default: begin cyc(ST_ADDI_EX, 1'b1, z, op, 1'b0); cyc(ST_ADDI_WB, 1'b1, z, op, 1'b0); end
    endcase
  endtask

  task automatic do_reset();
    cyc(ST_RST, 1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, bus_error};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cycle %0d: got=%05h want=%05h", cycle_no, got, want);
      end
      cycle_no++;
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // addi 0x20090005 with memory always ready
    run_instr(5, 0, 0, 1'b0);
    // lw with three stalled MEMRD cycles
    run_instr(1, 0, 3, 1'b0);
    // beq taken, then not taken
    run_instr(3, 0, 0, 1'b1);
    run_instr(3, 0, 0, 1'b0);

    // unsupported opcode: terminal until reset
    wait_phase(ST_FETCH, 0, 6'd0);
    cyc(ST_DECODE, 1'b1, 1'b0, 6'b111111, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(ST_ILL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
    do_reset();
    run_instr(0, 0, 0, 1'b0);

    // fetch times out after TMO+1 stalled cycles
    for (int k = 0; k <= int'(TMO); k++) cyc(ST_FETCH, 1'b0, 1'b0, 6'd0, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(ST_BERR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
    do_reset();
    // ready arriving exactly at the limit still advances normally, for fetch and memory waits
    run_instr(1, int'(TMO), int'(TMO), 1'b0);
    run_instr(2, int'(TMO), int'(TMO), 1'b0);
    // memory-state timeout
    wait_phase(ST_FETCH, 0, 6'd0);
    cyc(ST_DECODE, 1'b0, 1'b0, 6'b100011, 1'b0);
    cyc(ST_MEMADR, 1'b0, 1'b0, 6'b100011, 1'b0);
    for (int k = 0; k <= int'(TMO); k++) cyc(ST_MEMRD, 1'b0, 1'b0, 6'b100011, 1'b0);
    cyc(ST_BERR, 1'b1, 1'b1, 6'b100011, 1'b0);
    do_reset();

    // reset pulsed while a store waits in MEMWR
    wait_phase(ST_FETCH, 0, 6'd0);
    cyc(ST_DECODE, 1'b0, 1'b0, 6'b101011, 1'b0);
    cyc(ST_MEMADR, 1'b0, 1'b0, 6'b101011, 1'b0);
    cyc(ST_MEMWR, 1'b0, 1'b0, 6'b101011, 1'b0);
    do_reset();
    run_instr(4, 0, 0, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 80; n++)
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
